// File: rtl/cc_arb_pkg.sv
// Shared types and constants for the completer-completion arbiter.
package cc_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // tuser bit positions on the CC stream
  localparam int TUSER_ECRC        = 0;
  localparam int TUSER_DISCONTINUE = 3;
  localparam int TUSER_WIDTH       = 4;

  // Width of a port index; never narrower than one bit
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: scans last+1, last+2, ... modulo
// NUM_PORTS and returns the first requesting index.
module rr_pick
  import cc_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = ptr_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     last,
  output logic                 found,
  output logic [PTR_W-1:0]     idx
);

  // First requester after the last-served port wins; the last-served port is seen last
  always_comb begin
    int cand;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = (int'(last) + off) % NUM_PORTS;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cc_completion_arbiter.sv
// Packet-locked round-robin arbiter sharing one CC AXI-Stream path between
// NUM_PORTS completion sources. A granted source owns the output until its
// tlast handshake, so completions never interleave.
// Optional stall watchdog: define CC_ARB_WATCHDOG_EN.
//
// Handshake: a beat moves on any AXI-Stream interface only in a cycle where
// tvalid and tready are both 1; tvalid never waits on tready, and while
// LOCKED the output is a combinational pass-through of the owner, so
// s_tready[owner] follows m_tready in the same cycle.
module cc_completion_arbiter
  import cc_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_WIDTH     = 128,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            user_clk,
  input  logic                            user_reset_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  input  logic [NUM_PORTS*4-1:0]          s_tuser,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic [KEEP_WIDTH-1:0]           m_tkeep,
  output logic                            m_tlast,
  output logic [3:0]                      m_tuser,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_idx,
  output logic                            busy
`ifdef CC_ARB_WATCHDOG_EN
  ,
  output logic                            watchdog_evt
`endif
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cc_completion_arbiter: unsupported parameter set");
  end

  arb_state_t           state_q, state_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]     last_q, last_d;
  logic [NUM_PORTS-1:0] grant_oh;
  logic [NUM_PORTS-1:0] flush_q;
  logic [NUM_PORTS-1:0] pick_req;
  logic [PTR_W-1:0]     pick_last;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_found;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [3:0]            sel_user;
  logic                  sel_valid;
  logic                  sel_last;

  logic wd_fire;    // synthetic discontinue beat is being presented
  logic real_beat;  // owner's beat transfers this cycle
  logic eop;        // ownership ends this cycle (real tlast or synthetic beat)

  assign grant_oh = NUM_PORTS'(1) << grant_q;

  // Select the owner's stream slice
  always_comb begin
    sel_data  = s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    sel_keep  = s_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
    sel_user  = s_tuser[int'(grant_q)*4 +: 4];
    sel_valid = s_tvalid[grant_q];
    sel_last  = s_tlast[grant_q];
  end

  assign real_beat = (state_q == LOCKED) && sel_valid && m_tready && !wd_fire;
  assign eop       = (real_beat && sel_last) || (wd_fire && m_tready);

  // One shared picker: in IDLE it scans from the stored pointer; at end of
  // packet it scans from the finishing owner, which is therefore considered
  // last and only wins when nobody else requests. A port being flushed, or
  // the one just cut off by the watchdog, is never eligible.
  assign pick_last = (state_q == LOCKED) ? grant_q : last_q;
  assign pick_req  = s_tvalid & ~flush_q & ~(wd_fire ? grant_oh : '0);

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_pick (
    .req   (pick_req),
    .last  (pick_last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State, owner and round-robin pointer registers
  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PTR_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state: arbitrate in IDLE, re-arbitrate in the end-of-packet cycle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCKED;
          grant_d = pick_idx;
        end
      end
      LOCKED: begin
        if (eop) begin
          last_d = grant_q;
          if (pick_found) grant_d = pick_idx;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pass-through of the owner while LOCKED, synthetic beat on timeout
  always_comb begin
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tlast   = 1'b0;
    m_tuser   = '0;
    m_tvalid  = 1'b0;
    s_tready  = flush_q;
    busy      = (state_q == LOCKED);
    grant_idx = grant_q;
    if (state_q == LOCKED) begin
      if (wd_fire) begin
        m_tvalid                   = 1'b1;
        m_tlast                    = 1'b1;
        m_tuser[TUSER_DISCONTINUE] = 1'b1;
      end else begin
        m_tdata  = sel_data;
        m_tkeep  = sel_keep;
        m_tlast  = sel_last;
        m_tuser  = sel_user;
        m_tvalid = sel_valid;
        s_tready = s_tready | (m_tready ? grant_oh : '0);
      end
    end
  end

`ifdef CC_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;

  assign wd_fire      = (state_q == LOCKED) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES));
  assign watchdog_evt = wd_fire && m_tready;

  // Count owner-idle cycles; any beat or change of owner restarts the count
  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      wd_cnt_q <= '0;
    end else if (state_q != LOCKED || real_beat || eop) begin
      wd_cnt_q <= '0;
    end else if (!sel_valid && !wd_fire) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end

  // A timed-out source drains (and is ignored) up to and including its tlast
  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      flush_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (wd_fire && m_tready && grant_q == PTR_W'(i)) begin
          flush_q[i] <= 1'b1;
        end else if (flush_q[i] && s_tvalid[i] && s_tlast[i]) begin
          flush_q[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign wd_fire = 1'b0;
  assign flush_q = '0;
`endif

endmodule

// File: tb/tb_cc_completion_arbiter.sv
// Bench for cc_completion_arbiter: per-cycle vector table for the arbitration
// scenarios, a beat scoreboard, and a hand sequence for the stall watchdog
// when CC_ARB_WATCHDOG_EN is defined.
module tb_cc_completion_arbiter;

  localparam int NP  = 4;
  localparam int DW  = 128;
  localparam int KW  = DW / 8;
  localparam int TO  = 8;
  localparam int SBW = 4 + 1 + KW + DW;

  // ---------------- clock / reset ----------------
  logic user_clk = 1'b0;
  logic user_reset_n = 1'b0;
  always #5 user_clk = ~user_clk;

  logic [NP*DW-1:0] s_tdata = '0;
  logic [NP*KW-1:0] s_tkeep = '0;
  logic [NP-1:0]    s_tlast = '0;
  logic [NP*4-1:0]  s_tuser = '0;
  logic [NP-1:0]    s_tvalid = '0;
  logic [NP-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tlast;
  logic [3:0]       m_tuser;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic [1:0]       grant_idx;
  logic             busy;
`ifdef CC_ARB_WATCHDOG_EN
  logic             watchdog_evt;
`endif

  cc_completion_arbiter #(
    .NUM_PORTS      (NP),
    .DATA_WIDTH     (DW),
    .KEEP_WIDTH     (KW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .user_clk     (user_clk),
    .user_reset_n (user_reset_n),
    .s_tdata      (s_tdata),
    .s_tkeep      (s_tkeep),
    .s_tlast      (s_tlast),
    .s_tuser      (s_tuser),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tlast      (m_tlast),
    .m_tuser      (m_tuser),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .grant_idx    (grant_idx),
    .busy         (busy)
`ifdef CC_ARB_WATCHDOG_EN
    ,
    .watchdog_evt (watchdog_evt)
`endif
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [SBW-1:0] exp_q[$];
  int unsigned base[NP];
  int cnt[NP];

  typedef struct packed {
    logic       rst_n;
    logic       chk;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       mrdy;
    logic       exp_mv;
    logic       exp_busy;
    logic [1:0] exp_g;
    logic [3:0] exp_srdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic chk, logic [3:0] vld, logic [3:0] lst,
                              logic mrdy, logic mv, logic bsy, logic [1:0] g,
                              logic [3:0] srdy);
    vec_t v;
    v.rst_n = rst_n; v.chk = chk; v.vld = vld; v.lst = lst; v.mrdy = mrdy;
    v.exp_mv = mv; v.exp_busy = bsy; v.exp_g = g; v.exp_srdy = srdy;
    return v;
  endfunction

  function automatic logic [DW-1:0] make_data(int p, int c);
    return DW'({base[p], 8'(p), 16'(c)});
  endfunction

  function automatic logic [KW-1:0] make_keep(int p);
    logic [KW-1:0] k;
    k = '1;
    return k >> p;
  endfunction

  task automatic check(input string name, input logic [SBW-1:0] act, input logic [SBW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst_n, input logic [3:0] vld, input logic [3:0] lst,
                       input logic mrdy);
    @(negedge user_clk);
    user_reset_n = rst_n;
    s_tvalid     = vld;
    s_tlast      = lst;
    m_tready     = mrdy;
    for (int p = 0; p < NP; p++) begin
      s_tdata[p*DW +: DW] = make_data(p, cnt[p]);
      s_tkeep[p*KW +: KW] = make_keep(p);
      s_tuser[p*4 +: 4]   = 4'(p);
    end
    #1;
  endtask

  // Sources advance to their next beat after each accepted one
  task automatic post();
    for (int p = 0; p < NP; p++)
      if (s_tvalid[p] && s_tready[p]) cnt[p]++;
  endtask

  task automatic apply(input vec_t v, input int n);
    int g;
    g = int'(v.exp_g);
    drive(v.rst_n, v.vld, v.lst, v.mrdy);
    if (v.chk) begin
      check($sformatf("v%0d m_tvalid", n), SBW'(m_tvalid), SBW'(v.exp_mv));
      check($sformatf("v%0d busy", n), SBW'(busy), SBW'(v.exp_busy));
      check($sformatf("v%0d grant_idx", n), SBW'(grant_idx), SBW'(v.exp_g));
      check($sformatf("v%0d s_tready", n), SBW'(s_tready), SBW'(v.exp_srdy));
      if (v.exp_mv && v.mrdy)
        exp_q.push_back({4'(g), v.lst[g], make_keep(g), make_data(g, cnt[g])});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL v%0d beat: got unexpected beat %0h required none", n, m_tdata);
        end else begin
          check($sformatf("v%0d beat", n), {m_tuser, m_tlast, m_tkeep, m_tdata}, exp_q.pop_front());
        end
      end
    end
    post();
  endtask

  // ---------------- time limit ----------------
  initial begin
    #200000;
    $display("FAIL time_limit: got no finish, required finish before 200000");
    $fatal(1, "bench time limit");
  end

  // ---------------- test ----------------
  initial begin
    for (int p = 0; p < NP; p++) begin
      base[p] = $urandom;
      cnt[p]  = $urandom_range(0, 200);
    end

    //                 rst chk vld      lst      rdy mv bsy g  srdy
    // S1: ports 0 and 2 with 3-beat packets; port 2 follows with no gap
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b0101, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b0101, 4'b0000, 1, 1, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 1, 4'b0101, 4'b0000, 1, 1, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 1, 4'b0101, 4'b0001, 1, 1, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 1, 4'b0100, 4'b0000, 1, 1, 1, 2, 4'b0100));
    vecs.push_back(mk(1, 1, 4'b0100, 4'b0000, 1, 1, 1, 2, 4'b0100));
    vecs.push_back(mk(1, 1, 4'b0100, 4'b0100, 1, 1, 1, 2, 4'b0100));
    vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 1, 0, 1, 2, 4'b0100));
    // S2: all ports stream single-beat packets; strict 0,1,2,3,0 rotation
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b1111, 1, 1, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b1111, 1, 1, 1, 1, 4'b0010));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b1111, 1, 1, 1, 2, 4'b0100));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b1111, 1, 1, 1, 3, 4'b1000));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b1111, 1, 1, 1, 0, 4'b0001));
    // S3: port 1 packet under backpressure 1,0,0,1; port 3 waits
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b1010, 4'b0000, 1, 1, 1, 1, 4'b0010));
    vecs.push_back(mk(1, 1, 4'b1010, 4'b0000, 0, 1, 1, 1, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b1010, 4'b0000, 0, 1, 1, 1, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b1010, 4'b0010, 1, 1, 1, 1, 4'b0010));
    vecs.push_back(mk(1, 1, 4'b1000, 4'b1000, 1, 1, 1, 3, 4'b1000));
    // S4: lone requester regranted with zero bubble, then yields to port 0
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b0010, 4'b0010, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b0010, 4'b0010, 1, 1, 1, 1, 4'b0010));
    vecs.push_back(mk(1, 1, 4'b0010, 4'b0000, 1, 1, 1, 1, 4'b0010));
    vecs.push_back(mk(1, 1, 4'b0011, 4'b0010, 1, 1, 1, 1, 4'b0010));
    vecs.push_back(mk(1, 1, 4'b0001, 4'b0001, 1, 1, 1, 0, 4'b0001));
    // S5: reset in the middle of a port 2 packet
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b0100, 4'b0000, 1, 1, 1, 2, 4'b0100));
    vecs.push_back(mk(0, 0, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b0101, 4'b0000, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'b0101, 4'b0000, 1, 1, 1, 0, 4'b0001));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifdef CC_ARB_WATCHDOG_EN
    // Port 2 stalls after its first beat until the watchdog cuts it off
    drive(1'b0, 4'b0000, 4'b0000, 1'b1); post();
    drive(1'b1, 4'b0100, 4'b0000, 1'b1);
    check("wd idle busy", SBW'(busy), SBW'(0));
    post();
    drive(1'b1, 4'b0100, 4'b0000, 1'b1);
    check("wd beat1 valid", SBW'(m_tvalid), SBW'(1));
    check("wd beat1 grant", SBW'(grant_idx), SBW'(2));
    post();
    for (int k = 0; k < TO; k++) begin
      drive(1'b1, 4'b0000, 4'b0000, 1'b1);
      check($sformatf("wd stall%0d valid", k), SBW'(m_tvalid), SBW'(0));
      check($sformatf("wd stall%0d evt", k), SBW'(watchdog_evt), SBW'(0));
      post();
    end
    drive(1'b1, 4'b0000, 4'b0000, 1'b1);
    check("wd synth beat", {m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata},
          {1'b1, 1'b1, 4'b1000, {KW{1'b0}}, {DW{1'b0}}});
    check("wd synth evt", SBW'(watchdog_evt), SBW'(1));
    check("wd synth s_tready", SBW'(s_tready), SBW'(0));
    post();
    drive(1'b1, 4'b0100, 4'b0000, 1'b1);
    check("wd sink1 valid", SBW'(m_tvalid), SBW'(0));
    check("wd sink1 s_tready", SBW'(s_tready), SBW'(4'b0100));
    check("wd sink1 evt", SBW'(watchdog_evt), SBW'(0));
    post();
    drive(1'b1, 4'b0100, 4'b0100, 1'b1);
    check("wd sink2 valid", SBW'(m_tvalid), SBW'(0));
    check("wd sink2 s_tready", SBW'(s_tready), SBW'(4'b0100));
    check("wd sink2 busy", SBW'(busy), SBW'(0));
    post();
    drive(1'b1, 4'b0100, 4'b0000, 1'b1);
    check("wd rearb s_tready", SBW'(s_tready), SBW'(0));
    check("wd rearb busy", SBW'(busy), SBW'(0));
    post();
    drive(1'b1, 4'b0100, 4'b0000, 1'b1);
    check("wd regrant valid", SBW'(m_tvalid), SBW'(1));
    check("wd regrant grant", SBW'(grant_idx), SBW'(2));
    post();
`endif

    check("sb drained", SBW'(exp_q.size()), SBW'(0));

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
